// File: rtl/pulse_generator.sv
// Trigger-to-pulse generator: programmable delay and width, enforced low gap
// after each pulse, optional retrigger (restart in DELAY, extend in HIGH).
module pulse_generator #(
  parameter int unsigned DELAY_W    = 16,
  parameter int unsigned WIDTH_W    = 16,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned RETRIGGER  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_trigger,
  input  logic [DELAY_W-1:0] i_delay,
  input  logic [WIDTH_W-1:0] i_width,
  output logic               o_pulse,
  output logic               o_busy,
  output logic               o_rise,
  output logic               o_fall,
  output logic               o_drop
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, HIGH, GAP} state_t;

  state_t             state, state_nx;
  logic [DELAY_W-1:0] dly_cnt, dly_nx;
  logic [WIDTH_W-1:0] wid_cnt, wid_nx;
  logic [GAP_W-1:0]   gap_cnt, gap_nx;
  logic               drop_evt, drop_nx;
  logic [WIDTH_W-1:0] wid_ld;

  // A zero width request still yields a single-cycle pulse.
  assign wid_ld = (i_width == '0) ? WIDTH_W'(1) : i_width;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dly_cnt  <= '0;
      wid_cnt  <= '0;
      gap_cnt  <= '0;
      drop_evt <= 1'b0;
    end else begin
      state    <= state_nx;
      dly_cnt  <= dly_nx;
      wid_cnt  <= wid_nx;
      gap_cnt  <= gap_nx;
      drop_evt <= drop_nx;
    end
  end

  always_comb begin
    state_nx = state;
    dly_nx   = dly_cnt;
    wid_nx   = wid_cnt;
    gap_nx   = gap_cnt;
    drop_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (i_trigger) begin
          dly_nx   = i_delay;
          wid_nx   = wid_ld;
          state_nx = (i_delay == '0) ? HIGH : DELAY;
        end
      end
      DELAY: begin
        if (i_trigger && RETRIGGER != 0) begin
          dly_nx   = i_delay;
          wid_nx   = wid_ld;
          state_nx = (i_delay == '0) ? HIGH : DELAY;
        end else begin
          drop_nx = i_trigger;
          if (dly_cnt <= DELAY_W'(1)) begin
            dly_nx   = '0;
            state_nx = HIGH;
          end else begin
            dly_nx = dly_cnt - DELAY_W'(1);
          end
        end
      end
      HIGH: begin
        if (i_trigger && RETRIGGER != 0) begin
          wid_nx = wid_ld;
        end else begin
          drop_nx = i_trigger;
          if (wid_cnt <= WIDTH_W'(1)) begin
            wid_nx = '0;
            if (GAP_CYCLES > 0) begin
              gap_nx   = GAP_W'(GAP_CYCLES);
              state_nx = GAP;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            wid_nx = wid_cnt - WIDTH_W'(1);
          end
        end
      end
      GAP: begin
        drop_nx = i_trigger;
        if (gap_cnt <= GAP_W'(1)) begin
          gap_nx   = '0;
          state_nx = IDLE;
        end else begin
          gap_nx = gap_cnt - GAP_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are a registered view of the current state, one cycle behind it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_pulse <= 1'b0;
      o_busy  <= 1'b0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
      o_drop  <= 1'b0;
    end else begin
      o_pulse <= (state == HIGH);
      o_busy  <= (state != IDLE);
      o_rise  <= (state == HIGH) && !o_pulse;
      o_fall  <= o_pulse && (state != HIGH);
      o_drop  <= drop_evt;
    end
  end

endmodule

// File: tb/tb_pulse_generator.sv
// Directed bench for pulse_generator: cycle table on the drop-mode instance,
// plus hand sequences for gap boundary, retrigger, continuous trigger, reset.
module tb_pulse_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trig = 1'b0;
  logic [15:0] dly = '0;
  logic [15:0] wid = '0;
  logic        p0, b0, r0, f0, d0;
  logic        p1, b1, r1, f1, d1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        t;
    logic [15:0] d;
    logic [15:0] w;
    logic [4:0]  e;   // {pulse, busy, rise, fall, drop}
  } vec_t;
  vec_t vt[$];

  pulse_generator #(.DELAY_W(16), .WIDTH_W(16), .GAP_CYCLES(4), .RETRIGGER(0)) u_r0 (
    .clk(clk), .rst_n(rst_n), .i_trigger(trig), .i_delay(dly), .i_width(wid),
    .o_pulse(p0), .o_busy(b0), .o_rise(r0), .o_fall(f0), .o_drop(d0));

  pulse_generator #(.DELAY_W(16), .WIDTH_W(16), .GAP_CYCLES(4), .RETRIGGER(1)) u_r1 (
    .clk(clk), .rst_n(rst_n), .i_trigger(trig), .i_delay(dly), .i_width(wid),
    .o_pulse(p1), .o_busy(b1), .o_rise(r1), .o_fall(f1), .o_drop(d1));

  always #5 clk = ~clk;

  function automatic logic [4:0] out0();
    return {p0, b0, r0, f0, d0};
  endfunction

  function automatic logic [4:0] out1();
    return {p1, b1, r1, f1, d1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic drive(input logic t, input int d, input int w);
    trig = t;
    dly  = 16'(d);
    wid  = 16'(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input int n);
    drive(1'b0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic add(input logic t, input int d, input int w, input logic [4:0] e);
    vt.push_back('{t, 16'(d), 16'(w), e});
  endtask

  initial begin
    // Row k: inputs before edge k, expected outputs after edge k.
    add(1, 0, 1, 5'b00000);  // T: accept d=0 w=1
    add(0, 0, 0, 5'b11100);
    add(0, 0, 0, 5'b01010);
    add(0, 0, 0, 5'b01000);
    add(0, 0, 0, 5'b01000);
    add(0, 0, 0, 5'b01000);
    add(1, 3, 5, 5'b00000);  // T+6: busy low, accept d=3 w=5
    add(0, 0, 0, 5'b01000);
    add(0, 0, 0, 5'b01000);
    add(0, 0, 0, 5'b01000);
    add(0, 0, 0, 5'b11100);
    add(1, 7, 9, 5'b11000);  // trigger during HIGH is rejected
    add(0, 0, 0, 5'b11001);
    add(0, 0, 0, 5'b11000);
    add(0, 0, 0, 5'b11000);
    add(0, 0, 0, 5'b01010);
    add(0, 0, 0, 5'b01000);
    add(0, 0, 0, 5'b01000);
    add(0, 0, 0, 5'b01000);
    add(1, 1, 0, 5'b00000);  // width 0 behaves as 1
    add(0, 0, 0, 5'b01000);
    add(0, 0, 0, 5'b11100);
    add(0, 0, 0, 5'b01010);
    add(0, 0, 0, 5'b01000);
    add(0, 0, 0, 5'b01000);
    add(0, 0, 0, 5'b01000);
    add(0, 0, 0, 5'b00000);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset_r0", 32'(out0()), 32'(5'b00000));
    chk("reset_r1", 32'(out1()), 32'(5'b00000));
    rst_n = 1'b1;
    settle(2);

    foreach (vt[k]) begin
      drive(vt[k].t, int'(vt[k].d), int'(vt[k].w));
      step();
      chk($sformatf("table_row%0d", k), 32'(out0()), 32'(vt[k].e));
    end
    settle(30);

    // Trigger on the edge that leaves GAP is dropped; next cycle is accepted
    drive(1'b1, 0, 1);
    step();
    drive(1'b0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    drive(1'b1, 0, 1);
    step();
    step();
    chk("gap_edge_drop", 32'(d0), 32'(1));
    chk("gap_edge_busy", 32'(b0), 32'(0));
    drive(1'b0, 0, 0);
    step();
    chk("gap_next_accept", 32'({p0, r0, d0}), 32'(3'b110));
    settle(12);

    // Retrigger in HIGH extends the pulse; trigger in GAP is dropped
    for (int k = 0; k <= 10; k++) begin
      drive((k == 0) || (k == 2) || (k == 8), 0, 4);
      step();
      if (k >= 1) begin
        chk($sformatf("retrig_k%0d", k), 32'({p1, r1, f1, d1}),
            32'({(k <= 6), (k == 1), (k == 7), (k == 9)}));
      end
    end
    settle(12);

    // Trigger held high: one pulse every 1+D+W+GAP = 8 cycles
    drive(1'b1, 1, 2);
    for (int k = 0; k < 24; k++) begin
      step();
      chk($sformatf("cont_rise_k%0d", k), 32'(r0), 32'((k % 8) == 2));
    end
    settle(16);

    // Reset asserted mid-pulse clears outputs at once, no fall strobe
    drive(1'b1, 0, 10);
    step();
    drive(1'b0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    chk("pre_reset_pulse", 32'(p0), 32'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_r0", 32'(out0()), 32'(5'b00000));
    chk("mid_reset_r1", 32'(out1()), 32'(5'b00000));
    step();
    rst_n = 1'b1;
    step();
    chk("post_reset_r0", 32'(out0()), 32'(5'b00000));
    drive(1'b1, 2, 3);
    step();
    drive(1'b0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("post_reset_k%0d", k), 32'({p0, r0, f0}),
          32'({(k >= 3) && (k <= 5), (k == 3), (k == 6)}));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
